// File: rtl/serial_alu_seq.sv
// serial_alu_seq: bit-serial sequencer wrapped around a single one-bit ALU cell.
// Operands are fed to the cell LSB-first, one bit per clock. The cell's carry-out
// is registered and returned as the next carry-in. Result bits are collected
// into a WIDTH-bit word, and the final carry is reported with it.
module serial_alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin_in,
  output logic             alu_a,
  output logic             alu_b,
  output logic             alu_cin,
  output logic             alu_c0,
  output logic             alu_c1,
  input  logic             alu_y,
  input  logic             alu_z,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out
);

  // Bit counter width; the counter only ever spans 0..WIDTH-1.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_aSh;
  logic [WIDTH-1:0] r_bSh;
  logic [WIDTH-1:0] r_rSh;
  logic             r_carryQ;
  logic [1:0]       r_opQ;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_result;
  logic             r_carryOut;

  logic             w_inShift;
  logic [WIDTH-1:0] w_nextRSh;

  // The cell is only driven while bits are in flight; otherwise it sees zeros.
  always_comb begin
    w_inShift = (r_state == SHIFT);
    w_nextRSh = {alu_y, r_rSh[WIDTH-1:1]};
    alu_a     = w_inShift & r_aSh[0];
    alu_b     = w_inShift & r_bSh[0];
    alu_cin   = w_inShift & r_carryQ;
    alu_c0    = w_inShift & r_opQ[0];
    alu_c1    = w_inShift & r_opQ[1];
    busy      = w_inShift;
    done      = (r_state == DONE);
    result    = r_result;
    carry_out = r_carryOut;
  end

  // Sequencer state machine: capture on start, shift one bit per clock, then
  // publish result and carry for exactly one DONE cycle. Reset beats start.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_aSh      <= '0;
      r_bSh      <= '0;
      r_rSh      <= '0;
      r_carryQ   <= 1'b0;
      r_opQ      <= 2'b00;
      r_cnt      <= '0;
      r_result   <= '0;
      r_carryOut <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_aSh    <= a_in;
            r_bSh    <= b_in;
            r_carryQ <= cin_in;
            r_opQ    <= op;
            r_cnt    <= '0;
            r_state  <= SHIFT;
          end else begin
            r_state  <= IDLE;
          end
        end
        SHIFT: begin
          r_rSh    <= w_nextRSh;
          r_aSh    <= {1'b0, r_aSh[WIDTH-1:1]};
          r_bSh    <= {1'b0, r_bSh[WIDTH-1:1]};
          r_carryQ <= alu_z;
          if (r_cnt == LAST_BIT) begin
            r_result   <= w_nextRSh;
            r_carryOut <= alu_z;
            r_state    <= DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_alu_seq.sv
// tb_serial_alu_seq: directed tests of the serial ALU sequencer using a
// behavioural one-bit cell. Three instances cover WIDTH=8, 2 and 16.
module tb_serial_alu_seq;

  int checks = 0;
  int failures = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Behavioural one-bit cell, returns {z, y}.
  // op 00 = add, 01 = and, 10 = or, 11 = xor; non-add ops pass carry through.
  function automatic logic [1:0] cellEval(input logic c1, input logic c0,
                                           input logic a, input logic b,
                                           input logic cin);
    case ({c1, c0})
      2'b00:   return {(a & b) | (a & cin) | (b & cin), a ^ b ^ cin};
      2'b01:   return {cin, a & b};
      2'b10:   return {cin, a | b};
      default: return {cin, a ^ b};
    endcase
  endfunction

  // ---------------- WIDTH = 8 instance ----------------
  logic       start8 = 1'b0;
  logic [1:0] op8 = 2'b00;
  logic [7:0] a8 = '0, b8 = '0;
  logic       cin8 = 1'b0;
  logic       aluA8, aluB8, aluCin8, aluC08, aluC18, aluY8, aluZ8;
  logic       busy8, done8, carry8;
  logic [7:0] result8;

  assign {aluZ8, aluY8} = cellEval(aluC18, aluC08, aluA8, aluB8, aluCin8);

  serial_alu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .op(op8),
    .a_in(a8), .b_in(b8), .cin_in(cin8),
    .alu_a(aluA8), .alu_b(aluB8), .alu_cin(aluCin8),
    .alu_c0(aluC08), .alu_c1(aluC18),
    .alu_y(aluY8), .alu_z(aluZ8),
    .busy(busy8), .done(done8), .result(result8), .carry_out(carry8)
  );

  // ---------------- WIDTH = 2 instance ----------------
  logic       start2 = 1'b0;
  logic [1:0] a2 = '0, b2 = '0;
  logic       cin2 = 1'b0;
  logic       aluA2, aluB2, aluCin2, aluC02, aluC12, aluY2, aluZ2;
  logic       busy2, done2, carry2;
  logic [1:0] result2;

  assign {aluZ2, aluY2} = cellEval(aluC12, aluC02, aluA2, aluB2, aluCin2);

  serial_alu_seq #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .op(2'b00),
    .a_in(a2), .b_in(b2), .cin_in(cin2),
    .alu_a(aluA2), .alu_b(aluB2), .alu_cin(aluCin2),
    .alu_c0(aluC02), .alu_c1(aluC12),
    .alu_y(aluY2), .alu_z(aluZ2),
    .busy(busy2), .done(done2), .result(result2), .carry_out(carry2)
  );

  // ---------------- WIDTH = 16 instance ----------------
  logic        start16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        cin16 = 1'b0;
  logic        aluA16, aluB16, aluCin16, aluC016, aluC116, aluY16, aluZ16;
  logic        busy16, done16, carry16;
  logic [15:0] result16;

  assign {aluZ16, aluY16} = cellEval(aluC116, aluC016, aluA16, aluB16, aluCin16);

  serial_alu_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .op(2'b00),
    .a_in(a16), .b_in(b16), .cin_in(cin16),
    .alu_a(aluA16), .alu_b(aluB16), .alu_cin(aluCin16),
    .alu_c0(aluC016), .alu_c1(aluC116),
    .alu_y(aluY16), .alu_z(aluZ16),
    .busy(busy16), .done(done16), .result(result16), .carry_out(carry16)
  );

  // Every task starts and ends just after a falling edge. A start driven there
  // is accepted at the next rising edge (edge 0), and the following falling
  // edge is cycle 1.

  task automatic test_reset();
    logic [7:0] ctl;
    rst = 1'b1;
    start8 = 1'b1; op8 = 2'b11; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
    repeat (2) begin
      @(negedge clk);
      ctl = {busy8, done8, aluA8, aluB8, aluCin8, aluC08, aluC18, carry8};
      checks++;
      if (ctl !== 8'h00) begin
        failures++;
        $display("[TB] FAIL reset_ctl: got %b expected 00000000", ctl);
      end
      checks++;
      if (result8 !== 8'h00) begin
        failures++;
        $display("[TB] FAIL reset_result: got %h expected 00", result8);
      end
    end
    rst = 1'b0;
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    ctl = {busy8, done8, aluA8, aluB8, aluCin8, aluC08, aluC18, carry8};
    checks++;
    if (ctl !== 8'h00) begin
      failures++;
      $display("[TB] FAIL reset_stay_idle: got %b expected 00000000", ctl);
    end
    checks++;
    if ({busy2, done2, busy16, done16} !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL reset_sweep_idle: got %b expected 0000",
               {busy2, done2, busy16, done16});
    end
  endtask

  task automatic test_add();
    int doneCycle = -1;
    int doneCount = 0;
    int busyErr = 0;
    start8 = 1'b1; op8 = 2'b00; a8 = 8'h5A; b8 = 8'h27; cin8 = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) start8 = 1'b0;
      if (busy8 !== ((c >= 1) && (c <= 8))) busyErr++;
      if (done8 === 1'b1) begin
        doneCount++;
        if (doneCycle < 0) doneCycle = c;
      end
    end
    checks++;
    if (doneCycle !== 9) begin
      failures++;
      $display("[TB] FAIL add_done_cycle: got %0d expected 9", doneCycle);
    end
    checks++;
    if (doneCount !== 1) begin
      failures++;
      $display("[TB] FAIL add_done_count: got %0d expected 1", doneCount);
    end
    checks++;
    if (busyErr !== 0) begin
      failures++;
      $display("[TB] FAIL add_busy_window: got %0d bad cycles expected 0", busyErr);
    end
    checks++;
    if ({carry8, result8} !== 9'h081) begin
      failures++;
      $display("[TB] FAIL add_result: got %h expected 081", {carry8, result8});
    end
  endtask

  task automatic test_carry_chain();
    int firstDone = -1;
    int secondDone = -1;
    start8 = 1'b1; op8 = 2'b00; a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b0;
    for (int c = 1; c <= 12 && firstDone < 0; c++) begin
      @(negedge clk);
      if (c == 1) start8 = 1'b0;
      if (done8 === 1'b1) firstDone = c;
    end
    checks++;
    if (firstDone !== 9) begin
      failures++;
      $display("[TB] FAIL chain_first_done: got %0d expected 9", firstDone);
    end
    checks++;
    if ({carry8, result8} !== 9'h100) begin
      failures++;
      $display("[TB] FAIL chain_first_result: got %h expected 100", {carry8, result8});
    end
    start8 = 1'b1; op8 = 2'b00; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b1;
    for (int c = 1; c <= 12 && secondDone < 0; c++) begin
      @(negedge clk);
      if (c == 1) start8 = 1'b0;
      if (c == 5) begin
        checks++;
        if ({carry8, result8} !== 9'h100) begin
          failures++;
          $display("[TB] FAIL chain_result_held: got %h expected 100", {carry8, result8});
        end
      end
      if (done8 === 1'b1) secondDone = c;
    end
    checks++;
    if (secondDone !== 9) begin
      failures++;
      $display("[TB] FAIL chain_second_done: got %0d expected 9", secondDone);
    end
    checks++;
    if ({carry8, result8} !== 9'h001) begin
      failures++;
      $display("[TB] FAIL chain_second_result: got %h expected 001", {carry8, result8});
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_protocol();
    logic [7:0] expA;
    int doneCycle = -1;
    int doneCount = 0;
    int aErr = 0;
    int opErr = 0;
    int cinErr = 0;
    expA = 8'h5A;
    start8 = 1'b1; op8 = 2'b11; a8 = 8'h5A; b8 = 8'h3C; cin8 = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) start8 = 1'b0;
      if (c <= 8) begin
        if (aluA8 !== expA[c-1]) aErr++;
        if ({aluC18, aluC08} !== 2'b11) opErr++;
        if (aluCin8 !== 1'b1) cinErr++;
      end
      if (done8 === 1'b1) begin
        doneCount++;
        if (doneCycle < 0) doneCycle = c;
      end
      if (c == 3) begin
        start8 = 1'b1; op8 = 2'b00; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b0;
      end
      if (c == 4) start8 = 1'b0;
    end
    checks++;
    if (aErr !== 0) begin
      failures++;
      $display("[TB] FAIL proto_alu_a_seq: got %0d bad bits expected 0", aErr);
    end
    checks++;
    if (opErr !== 0) begin
      failures++;
      $display("[TB] FAIL proto_op_const: got %0d bad cycles expected 0", opErr);
    end
    checks++;
    if (cinErr !== 0) begin
      failures++;
      $display("[TB] FAIL proto_carry_feedback: got %0d bad cycles expected 0", cinErr);
    end
    checks++;
    if (doneCount !== 1 || doneCycle !== 9) begin
      failures++;
      $display("[TB] FAIL proto_single_done: got count %0d cycle %0d expected count 1 cycle 9",
               doneCount, doneCycle);
    end
    checks++;
    if ({carry8, result8} !== 9'h166) begin
      failures++;
      $display("[TB] FAIL proto_result: got %h expected 166", {carry8, result8});
    end
  endtask

  task automatic test_reset_mid_op();
    int doneCount = 0;
    int doneCycle = -1;
    start8 = 1'b1; op8 = 2'b00; a8 = 8'h11; b8 = 8'h22; cin8 = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) start8 = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({busy8, done8} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL midrst_idle: got %b expected 00", {busy8, done8});
    end
    checks++;
    if ({carry8, result8} !== 9'h000) begin
      failures++;
      $display("[TB] FAIL midrst_cleared: got %h expected 000", {carry8, result8});
    end
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done8 === 1'b1) doneCount++;
    end
    checks++;
    if (doneCount !== 0) begin
      failures++;
      $display("[TB] FAIL midrst_no_done: got %0d pulses expected 0", doneCount);
    end
    start8 = 1'b1; op8 = 2'b00; a8 = 8'hC8; b8 = 8'h50; cin8 = 1'b1;
    for (int c = 1; c <= 12 && doneCycle < 0; c++) begin
      @(negedge clk);
      if (c == 1) start8 = 1'b0;
      if (done8 === 1'b1) doneCycle = c;
    end
    checks++;
    if (doneCycle !== 9 || {carry8, result8} !== 9'h119) begin
      failures++;
      $display("[TB] FAIL midrst_recover: got cycle %0d value %h expected cycle 9 value 119",
               doneCycle, {carry8, result8});
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic runW2(input logic [1:0] a, input logic [1:0] b, input logic cin);
    logic [2:0] expSum;
    int doneCycle = -1;
    expSum = {1'b0, a} + {1'b0, b} + {2'b00, cin};
    start2 = 1'b1; a2 = a; b2 = b; cin2 = cin;
    for (int c = 1; c <= 8 && doneCycle < 0; c++) begin
      @(negedge clk);
      if (c == 1) start2 = 1'b0;
      if (done2 === 1'b1) doneCycle = c;
    end
    checks++;
    if (doneCycle !== 3 || {carry2, result2} !== expSum) begin
      failures++;
      $display("[TB] FAIL w2_add %h+%h+%b: got cycle %0d value %h expected cycle 3 value %h",
               a, b, cin, doneCycle, {carry2, result2}, expSum);
    end
  endtask

  task automatic runW16(input logic [15:0] a, input logic [15:0] b, input logic cin);
    logic [16:0] expSum;
    int doneCycle = -1;
    expSum = {1'b0, a} + {1'b0, b} + {16'h0000, cin};
    start16 = 1'b1; a16 = a; b16 = b; cin16 = cin;
    for (int c = 1; c <= 24 && doneCycle < 0; c++) begin
      @(negedge clk);
      if (c == 1) start16 = 1'b0;
      if (done16 === 1'b1) doneCycle = c;
    end
    checks++;
    if (doneCycle !== 17 || {carry16, result16} !== expSum) begin
      failures++;
      $display("[TB] FAIL w16_add %h+%h+%b: got cycle %0d value %h expected cycle 17 value %h",
               a, b, cin, doneCycle, {carry16, result16}, expSum);
    end
  endtask

  task automatic test_sweep();
    runW2(2'd3, 2'd3, 1'b1);
    runW2(2'd1, 2'd2, 1'b0);
    runW2(2'd2, 2'd2, 1'b0);
    for (int i = 0; i < 2; i++)
      runW2(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    runW16(16'hFFFF, 16'h0001, 1'b0);
    runW16(16'h1234, 16'h4321, 1'b1);
    runW16(16'h8000, 16'h8000, 1'b1);
    for (int i = 0; i < 2; i++)
      runW16(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
  endtask

  // Test sequence.
  initial begin
    test_reset();
    test_add();
    test_carry_chain();
    test_protocol();
    test_reset_mid_op();
    test_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
